// File: rtl/hero_write_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : hero_write_arb_if                                           |
// | Brief  : Bundle of per-channel hero-bus write inputs and the merged  |
// |          hero-bus write output of hero_write_arb.                    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface hero_write_arb_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 36
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Per-channel source side
  logic [NUM_CH*4-1:0]          in_cycle_type;
  logic [NUM_CH*DATA_WIDTH-1:0] in_wdat;
  logic [NUM_CH-1:0]            in_clk_en;
  logic [NUM_CH-1:0]            in_ready;

  // Merged output side
  logic [3:0]                   out_cycle_type;
  logic [DATA_WIDTH-1:0]        out_wdat;
  logic                         out_clk_en;
  logic                         out_ready;
  logic [CH_W-1:0]              out_ch;

  // Status
  logic [NUM_CH-1:0]            err_illegal;

  // Sources and downstream sink
  modport master (
    output in_cycle_type, in_wdat, in_clk_en, out_ready,
    input  in_ready, out_cycle_type, out_wdat, out_clk_en, out_ch, err_illegal
  );

  // Arbiter
  modport slave (
    input  in_cycle_type, in_wdat, in_clk_en, out_ready,
    output in_ready, out_cycle_type, out_wdat, out_clk_en, out_ch, err_illegal
  );
endinterface
`default_nettype wire

// File: rtl/hero_write_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : hero_write_arb                                              |
// | Brief  : N-channel hero-bus write arbiter. Per-channel beat FIFOs    |
// |          feed a transaction-granular round-robin arbiter and a       |
// |          single registered output stage with backpressure.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module hero_write_arb #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 36,
  parameter int FIFO_DEPTH = 4
) (
  input wire              clk,
  input wire              rst_n,
  hero_write_arb_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0]       CT_IDLE   = 4'd0;
  localparam logic [3:0]       CT_VALID  = 4'd1;
  localparam logic [3:0]       CT_DONE   = 4'd2;
  localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [CH_W-1:0]  C_LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]    C_NUM_CH  = (CH_W + 1)'(NUM_CH);

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Per-channel FIFO status and head beat ({is_done, wdat})
  logic [NUM_CH-1:0]               w_push;
  logic [NUM_CH-1:0]               w_pop;
  logic [NUM_CH-1:0]               w_nonempty;
  logic [NUM_CH-1:0]               w_ready;
  logic [NUM_CH-1:0]               w_err;
  logic [NUM_CH-1:0][DATA_WIDTH:0] w_head;

  // Arbiter
  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [CH_W-1:0]     r_rr;
  logic [CH_W-1:0]     w_rr_nxt;
  logic [CH_W-1:0]     r_lock;
  logic [CH_W-1:0]     w_lock_nxt;
  logic [CH_W-1:0]     w_grant;
  logic [CH_W-1:0]     w_grant_inc;
  logic [CH_W-1:0]     w_idx;
  logic [CH_W:0]       w_sum;
  logic                w_load;
  logic                w_pop_en;
  logic [DATA_WIDTH:0] w_head_sel;
  logic                w_head_done;

  // Output stage
  logic                  r_out_vld;
  logic [3:0]            r_out_ct;
  logic [DATA_WIDTH-1:0] r_out_wdat;
  logic [CH_W-1:0]       r_out_ch;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [3:0]          w_ct;
      logic                w_offer;
      logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]    r_wptr;
      logic [PTR_W-1:0]    r_rptr;
      logic [CNT_W-1:0]    r_cnt;
      logic                r_err;

      assign w_ct           = bus.in_cycle_type[4*gi +: 4];
      assign w_offer        = bus.in_clk_en[gi] && ((w_ct == CT_VALID) || (w_ct == CT_DONE));
      // Ready depends on occupancy only, so a same-cycle pop never opens the slot early.
      assign w_ready[gi]    = (r_cnt < C_FULL);
      assign w_nonempty[gi] = (r_cnt != '0);
      assign w_push[gi]     = w_offer && w_ready[gi];
      assign w_head[gi]     = r_mem[r_rptr];
      assign w_err[gi]      = r_err;

      // Beat storage; contents are only meaningful below the count, so no reset.
      always_ff @(posedge clk) begin
        if (w_push[gi]) begin
          r_mem[r_wptr] <= {(w_ct == CT_DONE), bus.in_wdat[DATA_WIDTH*gi +: DATA_WIDTH]};
        end
      end

      // Pointers, occupancy and sticky illegal-encoding flag.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
          r_err  <= 1'b0;
        end else begin
          if (w_push[gi]) r_wptr <= r_wptr + 1'b1;
          if (w_pop[gi])  r_rptr <= r_rptr + 1'b1;
          if (w_push[gi] && !w_pop[gi]) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!w_push[gi] && w_pop[gi]) begin
            r_cnt <= r_cnt - 1'b1;
          end
          if (bus.in_clk_en[gi] && (w_ct > CT_DONE)) r_err <= 1'b1;
        end
      end
    end
  endgenerate

  // The output register accepts a new beat when empty or being drained.
  assign w_load = !r_out_vld || bus.out_ready;

  // Grant: the locked channel, else the first non-empty channel at or after rr.
  always_comb begin
    w_grant  = r_lock;
    w_pop_en = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    if (r_state == ARB_LOCKED) begin
      w_pop_en = w_load && w_nonempty[r_lock];
    end else begin
      // Walk from farthest to nearest so the nearest non-empty channel wins.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        w_sum = {1'b0, r_rr} + (CH_W + 1)'(k);
        if (w_sum >= C_NUM_CH) w_sum = w_sum - C_NUM_CH;
        w_idx = w_sum[CH_W-1:0];
        if (w_nonempty[w_idx]) begin
          w_grant  = w_idx;
          w_pop_en = w_load;
        end
      end
    end
  end

  // One-hot pop of the granted channel.
  always_comb begin
    w_pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_pop[c] = w_pop_en && (w_grant == CH_W'(c));
    end
  end

  assign w_head_sel  = w_head[w_grant];
  assign w_head_done = w_head_sel[DATA_WIDTH];
  assign w_grant_inc = (w_grant == C_LAST_CH) ? '0 : (w_grant + 1'b1);

  // Next state: VALID from idle locks the channel, DONE releases and advances rr.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_lock_nxt  = r_lock;
    if (w_pop_en) begin
      if (w_head_done) begin
        w_state_nxt = ARB_IDLE;
        w_rr_nxt    = w_grant_inc;
      end else if (r_state == ARB_IDLE) begin
        w_state_nxt = ARB_LOCKED;
        w_lock_nxt  = w_grant;
      end
    end
  end

  // Arbiter state, round-robin pointer and locked channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_rr    <= '0;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  // Output register: load the popped beat, or go empty (IDLE bubble) when nothing pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_ct   <= CT_IDLE;
      r_out_wdat <= '0;
      r_out_ch   <= '0;
    end else if (w_load) begin
      if (w_pop_en) begin
        r_out_vld  <= 1'b1;
        r_out_ct   <= w_head_done ? CT_DONE : CT_VALID;
        r_out_wdat <= w_head_sel[DATA_WIDTH-1:0];
        r_out_ch   <= w_grant;
      end else begin
        r_out_vld  <= 1'b0;
        r_out_ct   <= CT_IDLE;
        r_out_wdat <= '0;
        r_out_ch   <= '0;
      end
    end
  end

  assign bus.in_ready       = w_ready;
  assign bus.err_illegal    = w_err;
  assign bus.out_clk_en     = r_out_vld;
  assign bus.out_cycle_type = r_out_ct;
  assign bus.out_wdat       = r_out_wdat;
  assign bus.out_ch         = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_hero_write_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_hero_write_arb                                           |
// | Brief  : Scoreboard bench for hero_write_arb: directed scenarios     |
// |          plus randomized multi-channel traffic.                      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_hero_write_arb;
  localparam int NUM_CH = 4;
  localparam int DW     = 36;
  localparam int DEPTH  = 4;
  localparam logic [3:0] CT_IDLE  = 4'd0;
  localparam logic [3:0] CT_VALID = 4'd1;
  localparam logic [3:0] CT_DONE  = 4'd2;

  typedef struct packed {
    logic [1:0]    ch;
    logic [3:0]    ct;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    int    cyc;
    beat_t b;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;

  hero_write_arb_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();

  hero_write_arb #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: per-channel expected beats, plus a log of accepted output beats.
  beat_t exp_q [NUM_CH][$];
  obs_t  obs[$];
  int    cyc     = 0;
  int    n_chk   = 0;
  int    n_pass  = 0;
  int    open_ch = -1;
  int    n_acc   = 0;
  logic  rand_on = 1'b0;
  logic  hold_vld = 1'b0;
  beat_t hold_val;
  beat_t mon_cur;
  beat_t mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic int sb_size();
    int s = 0;
    for (int c = 0; c < NUM_CH; c++) s += exp_q[c].size();
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every accepted output beat.
  always @(negedge clk) begin
    mon_cur = {bus.out_ch, bus.out_cycle_type, bus.out_wdat};
    if (!rst_n) begin
      open_ch  = -1;
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) check("hold_stable", 64'({bus.out_clk_en, mon_cur}), 64'({1'b1, hold_val}));
      if (!bus.out_clk_en) check("empty_out", 64'(mon_cur), 64'(0));
      if (bus.out_clk_en && bus.out_ready) begin
        if (open_ch >= 0) check("no_interleave", 64'(bus.out_ch), 64'(open_ch));
        open_ch = (bus.out_cycle_type == CT_VALID) ? int'(bus.out_ch) : -1;
        if (exp_q[bus.out_ch].size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got ch%0d ct%0d data 0x%0h, required no beat",
                   bus.out_ch, bus.out_cycle_type, bus.out_wdat);
        end else begin
          mon_exp = exp_q[bus.out_ch].pop_front();
          check("beat", 64'(mon_cur), 64'(mon_exp));
        end
        obs.push_back('{cyc: cyc, b: mon_cur});
      end
      hold_vld = bus.out_clk_en && !bus.out_ready;
      hold_val = mon_cur;
    end
  end

  // Offer one beat on a channel and hold it until accepted; acc = accepting edge.
  task automatic offer(input int ch, input logic [3:0] ct, input logic [DW-1:0] d, output int acc);
    int guard = 0;
    bus.in_cycle_type[ch*4 +: 4] = ct;
    bus.in_wdat[ch*DW +: DW]     = d;
    bus.in_clk_en[ch]            = 1'b1;
    acc = -1;
    while (acc < 0) begin
      @(negedge clk);
      if (bus.in_ready[ch]) begin
        if ((ct == CT_VALID) || (ct == CT_DONE)) exp_q[ch].push_back({2'(ch), ct, d});
        @(posedge clk);
        #1;
        acc = cyc;
      end else begin
        guard++;
        if (guard > 300) begin
          n_chk++;
          $display("FAIL offer_timeout: ch%0d in_ready low for 300 cycles, required high", ch);
          acc = cyc;
        end
      end
    end
    bus.in_clk_en[ch]            = 1'b0;
    bus.in_cycle_type[ch*4 +: 4] = CT_IDLE;
  endtask

  task automatic send_txn(input int ch, input int n, input logic [DW-1:0] base, output int first);
    int acc;
    first = -1;
    for (int i = 0; i < n; i++) begin
      offer(ch, (i == n - 1) ? CT_DONE : CT_VALID, base + DW'(i), acc);
      if (i == 0) first = acc;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    @(negedge clk);
    while (((sb_size() != 0) || bus.out_clk_en) && (n < 1000)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(sb_size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_stream(input int ch);
    int len;
    int acc;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        offer(ch, (b == len - 1) ? CT_DONE : CT_VALID, {$urandom(), 4'(b)}, acc);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  int a0, a1, a2, a3, acc;
  int s2_ch [6] = '{1, 1, 1, 3, 3, 3};
  int s3_ch [5] = '{2, 2, 2, 0, 0};
  int s3_off[5] = '{1, 5, 6, 7, 8};

  initial begin
    rst_n             = 1'b0;
    bus.in_cycle_type = '0;
    bus.in_wdat       = '0;
    bus.in_clk_en     = '0;
    bus.out_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_clk_en", 64'(bus.out_clk_en), 64'(0));
    check("rst_out_ct",     64'(bus.out_cycle_type), 64'(CT_IDLE));
    check("rst_out_wdat",   64'(bus.out_wdat), 64'(0));
    check("rst_out_ch",     64'(bus.out_ch), 64'(0));
    check("rst_in_ready",   64'(bus.in_ready), 64'(4'hF));
    check("rst_err",        64'(bus.err_illegal), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single channel: three beats, one cycle latency, back to back.
    obs.delete();
    offer(0, CT_VALID, 36'h1, a0);
    offer(0, CT_VALID, 36'h2, acc);
    offer(0, CT_DONE,  36'h3, acc);
    wait_drain("s1");
    check("s1_count", 64'(obs.size()), 64'(3));
    if (obs.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("s1_cycle", 64'(obs[i].cyc), 64'(a0 + 1 + i));
        check("s1_ch",    64'(obs[i].b.ch), 64'(0));
        check("s1_ct",    64'(obs[i].b.ct), 64'((i == 2) ? CT_DONE : CT_VALID));
      end
    end
    check("s1_idle_after", 64'(bus.out_cycle_type), 64'(CT_IDLE));

    // Contention after reset: ch1 and ch3 queue together; ch1 wins, ch3 follows with no bubble.
    pulse_reset();
    obs.delete();
    fork
      send_txn(1, 3, 36'h11, a1);
      send_txn(3, 3, 36'h31, a3);
    join
    wait_drain("s2");
    check("s2_count", 64'(obs.size()), 64'(6));
    if (obs.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("s2_ch",    64'(obs[i].b.ch), 64'(s2_ch[i]));
        check("s2_cycle", 64'(obs[i].cyc), 64'(a1 + 1 + i));
      end
    end

    // Lock with starvation: ch2 VALID, 3-cycle stall while ch0 waits.
    obs.delete();
    fork
      begin
        offer(2, CT_VALID, 36'h21, a2);
        repeat (3) @(posedge clk);
        #1;
        offer(2, CT_VALID, 36'h22, acc);
        offer(2, CT_DONE,  36'h23, acc);
      end
      begin
        @(posedge clk);
        #1;
        send_txn(0, 2, 36'h01, a0);
      end
    join
    wait_drain("s3");
    check("s3_count", 64'(obs.size()), 64'(5));
    if (obs.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("s3_ch",    64'(obs[i].b.ch), 64'(s3_ch[i]));
        check("s3_cycle", 64'(obs[i].cyc), 64'(a2 + s3_off[i]));
      end
    end

    // Backpressure: output stalled, ch0 pushes 6 beats into a 4-deep FIFO.
    obs.delete();
    bus.out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          offer(0, (i == 5) ? CT_DONE : CT_VALID, 36'h40 + DW'(i), acc);
          n_acc++;
          if (i == 3) check("s4_ready_after_4", 64'(bus.in_ready[0]), 64'(1));
          if (i == 4) check("s4_ready_after_5", 64'(bus.in_ready[0]), 64'(0));
        end
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        check("s4_accepted", 64'(n_acc), 64'(DEPTH + 1));
        check("s4_in_ready", 64'(bus.in_ready[0]), 64'(0));
        check("s4_held_wdat", 64'(bus.out_wdat), 64'(36'h40));
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("s4");
    check("s4_count", 64'(obs.size()), 64'(6));
    if (obs.size() == 6) begin
      for (int i = 1; i < 6; i++) check("s4_consecutive", 64'(obs[i].cyc), 64'(obs[0].cyc + i));
    end

    // Illegal encoding on ch1: discarded, sticky error bit.
    obs.delete();
    offer(1, 4'd5, 36'h55, acc);
    repeat (4) @(posedge clk);
    #1;
    check("s5_err",     64'(bus.err_illegal), 64'(4'b0010));
    check("s5_no_beat", 64'(obs.size()), 64'(0));
    send_txn(1, 1, 36'h56, acc);
    wait_drain("s5");
    check("s5_legal_count", 64'(obs.size()), 64'(1));
    check("s5_err_sticky",  64'(bus.err_illegal), 64'(4'b0010));

    // Reset mid-transaction: outputs clear asynchronously, no DONE emitted.
    obs.delete();
    bus.out_ready = 1'b0;
    offer(2, CT_VALID, 36'h61, acc);
    offer(2, CT_VALID, 36'h62, acc);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("s6_clk_en",   64'(bus.out_clk_en), 64'(0));
    check("s6_ct",       64'(bus.out_cycle_type), 64'(CT_IDLE));
    check("s6_wdat",     64'(bus.out_wdat), 64'(0));
    check("s6_ch",       64'(bus.out_ch), 64'(0));
    check("s6_err",      64'(bus.err_illegal), 64'(0));
    check("s6_in_ready", 64'(bus.in_ready), 64'(4'hF));
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    offer(3, CT_DONE, 36'h7F, a3);
    wait_drain("s6");
    check("s6_count", 64'(obs.size()), 64'(1));
    if (obs.size() == 1) begin
      check("s6_out_ch", 64'(obs[0].b.ch), 64'(3));
      check("s6_cycle",  64'(obs[0].cyc), 64'(a3 + 1));
      check("s6_ct_done", 64'(obs[0].b.ct), 64'(CT_DONE));
    end

    // Randomized traffic on all channels with random output backpressure.
    rand_on = 1'b1;
    fork
      begin
        fork
          rand_stream(0);
          rand_stream(1);
          rand_stream(2);
          rand_stream(3);
        join
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("rand");
    check("final_sb_empty", 64'(sb_size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
